// File: rtl/gpio_bank_pkg.sv
// Shared register map, bus-side access payload and helpers for the GPIO bank.
package gpio_bank_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] REG_OUT     = 3'd0;
  localparam logic [2:0] REG_SET     = 3'd1;
  localparam logic [2:0] REG_CLR     = 3'd2;
  localparam logic [2:0] REG_TGL     = 3'd3;
  localparam logic [2:0] REG_IN      = 3'd4;
  localparam logic [2:0] REG_RISE_EN = 3'd5;
  localparam logic [2:0] REG_FALL_EN = 3'd6;
  localparam logic [2:0] REG_EVT     = 3'd7;

  // Decoded access broadcast to every port slice; data is already byte-masked.
  typedef struct packed {
    logic [2:0]       reg_sel;
    logic [BUS_W-1:0] mask;
    logic [BUS_W-1:0] data;
  } gpio_acc_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/gpio_port_slice.sv
// One GPIO port: output register, input synchroniser, edge detect, sticky event flags.
module gpio_port_slice
  import gpio_bank_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0
) (
  input  logic             clk24,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin,
  input  logic             wr_en,
  input  gpio_acc_t        acc,
  output logic [WIDTH-1:0] out_q,
  output logic [31:0]      rd_word_c,
  output logic             evt_any_c
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] evt_q;

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;
  logic [WIDTH-1:0] clr_c;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] rise_en_nxt;
  logic [WIDTH-1:0] fall_en_nxt;
  logic [WIDTH-1:0] evt_nxt;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign mask   = acc.mask[WIDTH-1:0];
  assign data   = acc.data[WIDTH-1:0];
  assign rise_c = sync & ~prev_q;
  assign fall_c = ~sync & prev_q;

  // Register updates; a fresh edge always wins over a same-cycle W1C.
  always_comb begin
    out_nxt     = out_q;
    rise_en_nxt = rise_en_q;
    fall_en_nxt = fall_en_q;
    clr_c       = '0;
    if (wr_en) begin
      case (acc.reg_sel)
        REG_OUT:     out_nxt     = (out_q & ~mask) | data;
        REG_SET:     out_nxt     = out_q | data;
        REG_CLR:     out_nxt     = out_q & ~data;
        REG_TGL:     out_nxt     = out_q ^ data;
        REG_RISE_EN: rise_en_nxt = (rise_en_q & ~mask) | data;
        REG_FALL_EN: fall_en_nxt = (fall_en_q & ~mask) | data;
        REG_EVT:     clr_c       = data;
        default:     clr_c       = '0;
      endcase
    end
    evt_nxt = (evt_q & ~clr_c) | (rise_c & rise_en_q) | (fall_c & fall_en_q);
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q    <= '0;
      out_q     <= OUT_RESET[WIDTH-1:0];
      rise_en_q <= '0;
      fall_en_q <= '0;
      evt_q     <= '0;
    end else begin
      sync_q[0] <= pin;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q    <= sync;
      out_q     <= out_nxt;
      rise_en_q <= rise_en_nxt;
      fall_en_q <= fall_en_nxt;
      evt_q     <= evt_nxt;
    end
  end

  // Read word is zero-extended to the bus width.
  always_comb begin
    rd_word_c = '0;
    case (acc.reg_sel)
      REG_OUT, REG_SET, REG_CLR, REG_TGL: rd_word_c = 32'(out_q);
      REG_IN:      rd_word_c = 32'(sync);
      REG_RISE_EN: rd_word_c = 32'(rise_en_q);
      REG_FALL_EN: rd_word_c = 32'(fall_en_q);
      REG_EVT:     rd_word_c = 32'(evt_q);
      default:     rd_word_c = '0;
    endcase
  end

  assign evt_any_c = |(evt_q & (rise_en_q | fall_en_q));

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank on the picorv32 native bus: decode, handshake, read mux, irq.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  localparam int unsigned ADDR_W     = clog2(NUM_PORTS) + 3
) (
  input  logic                       clk24,
  input  logic                       reset,
  input  logic                       sel,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [3:0]                 wstrb,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       ready,
  input  logic [NUM_PORTS*WIDTH-1:0] gp_in,
  output logic [NUM_PORTS*WIDTH-1:0] gp_out,
  output logic                       irq
);

  // Wide enough for any address-space port index, including out-of-range ones.
  localparam int unsigned PORT_IDX_W = 5;

  logic                  access_c;
  logic [PORT_IDX_W-1:0] port_idx;
  logic [31:0]           byte_mask;
  gpio_acc_t             acc;
  logic [NUM_PORTS-1:0]  wr_hit;
  logic [NUM_PORTS-1:0]  evt_any;
  logic [31:0]           rd_word [NUM_PORTS];
  logic [31:0]           rd_mux;

  assign access_c = sel & ~ready;
  assign port_idx = PORT_IDX_W'(addr >> 3);

  always_comb begin
    byte_mask = '0;
    for (int unsigned b = 0; b < 4; b++) byte_mask[8*b +: 8] = {8{wstrb[b]}};
  end

  always_comb begin
    acc         = '0;
    acc.reg_sel = addr[2:0];
    acc.mask    = byte_mask;
    acc.data    = wdata & byte_mask;
  end

  // Only a write access phase commits; out-of-range ports match no slice.
  always_comb begin
    wr_hit = '0;
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (port_idx == PORT_IDX_W'(i)) begin
        wr_hit[i] = access_c & (|wstrb);
        rd_mux    = rd_word[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    gpio_port_slice #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .OUT_RESET   (OUT_RESET)
    ) u_slice (
      .clk24     (clk24),
      .reset     (reset),
      .pin       (gp_in[g*WIDTH +: WIDTH]),
      .wr_en     (wr_hit[g]),
      .acc       (acc),
      .out_q     (gp_out[g*WIDTH +: WIDTH]),
      .rd_word_c (rd_word[g]),
      .evt_any_c (evt_any[g])
    );
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      ready <= 1'b0;
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      ready <= access_c;
      rdata <= access_c ? rd_mux : '0;
      irq   <= |evt_any;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (3 ports x 32 bits, OUT reset 0xA5).
module tb_gpio_bank;
  import gpio_bank_pkg::*;

  localparam int unsigned NP = 3;
  localparam int unsigned W  = 32;
  localparam int unsigned SS = 2;
  localparam logic [31:0] ORST = 32'hA5;
  localparam int unsigned AW = clog2(NP) + 3;

  logic            clk24;
  logic            reset;
  logic            sel;
  logic [AW-1:0]   addr;
  logic [3:0]      wstrb;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            ready;
  logic [NP*W-1:0] gp_in;
  logic [NP*W-1:0] gp_out;
  logic            irq;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] rd;
  logic        irq_at_ack;

  gpio_bank #(
    .NUM_PORTS   (NP),
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .OUT_RESET   (ORST)
  ) dut (
    .clk24  (clk24),
    .reset  (reset),
    .sel    (sel),
    .addr   (addr),
    .wstrb  (wstrb),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .gp_in  (gp_in),
    .gp_out (gp_out),
    .irq    (irq)
  );

  initial clk24 = 1'b0;
  always #5 clk24 = ~clk24;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] ra(input int unsigned p, input logic [2:0] r);
    return AW'(p * 8 + 32'(r));
  endfunction

  // One bus access: sel held through access and ready cycles; pre = idle cycles first.
  task automatic bus(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d,
                     input int unsigned pre, output logic [31:0] r);
    repeat (pre) @(posedge clk24);
    @(posedge clk24); #1;
    sel = 1'b1; addr = a; wstrb = s; wdata = d;
    check("ready_low_in_access", 96'(ready), 96'(0));
    @(posedge clk24); #1;
    check("ready_ack", 96'(ready), 96'(1));
    r = rdata;
    irq_at_ack = irq;
    @(posedge clk24); #1;
    check("ready_single_pulse", 96'(ready), 96'(0));
    sel = 1'b0; wstrb = 4'h0; wdata = 32'h0;
  endtask

  initial begin
    sel = 1'b0; addr = '0; wstrb = 4'h0; wdata = 32'h0;
    gp_in = '1; reset = 1'b1; irq_at_ack = 1'b0;

    // Reset state
    repeat (2) @(posedge clk24); #1;
    check("rst_gp_out", 96'(gp_out), {32'hA5, 32'hA5, 32'hA5});
    check("rst_ready", 96'(ready), 96'(0));
    check("rst_irq", 96'(irq), 96'(0));
    check("rst_rdata", 96'(rdata), 96'(0));
    reset = 1'b0;

    // Pins high at reset release: IN reads 1, no event while enables are 0
    bus(ra(0, REG_IN), 4'h0, 32'h0, 2, rd);
    check("in_p0_high", 96'(rd), 96'(32'hFFFF_FFFF));
    bus(ra(0, REG_EVT), 4'h0, 32'h0, 0, rd);
    check("evt_p0_no_event_at_release", 96'(rd), 96'(0));
    check("irq_idle", 96'(irq), 96'(0));
    gp_in = '0;
    repeat (4) @(posedge clk24);

    // Byte-strobed OUT write and SET/CLR aliases on port 0
    bus(ra(0, REG_OUT), 4'b0011, 32'h0000_FFFF, 0, rd);
    check("out_p0_strobed", 96'(gp_out[31:0]), 96'(32'h0000_FFFF));
    bus(ra(0, REG_SET), 4'hF, 32'h0001_0000, 0, rd);
    bus(ra(0, REG_CLR), 4'hF, 32'h0000_0001, 0, rd);
    bus(ra(0, REG_OUT), 4'h0, 32'h0, 0, rd);
    check("out_p0_set_clr", 96'(rd), 96'(32'h0001_FFFE));
    bus(ra(0, REG_SET), 4'b1000, 32'h0F0F_0000, 0, rd);
    bus(ra(0, REG_SET), 4'h0, 32'h0, 0, rd);
    check("set_alias_strobe", 96'(rd), 96'(32'h0F01_FFFE));
    bus(ra(0, REG_CLR), 4'b1000, 32'hFF00_0000, 0, rd);
    check("clr_p0_restore", 96'(gp_out[31:0]), 96'(32'h0001_FFFE));

    // TGL acts exactly once although sel spans access and ready cycles
    bus(ra(1, REG_OUT), 4'hF, 32'h0, 0, rd);
    bus(ra(1, REG_TGL), 4'hF, 32'h0000_00F0, 0, rd);
    check("tgl_p1_once_gp_out", 96'(gp_out[63:32]), 96'(32'h0000_00F0));
    bus(ra(1, REG_TGL), 4'h0, 32'h0, 0, rd);
    check("tgl_p1_read", 96'(rd), 96'(32'h0000_00F0));

    // Enabling over a pre-existing high level creates no event
    gp_in[37] = 1'b1;
    repeat (4) @(posedge clk24);
    bus(ra(1, REG_RISE_EN), 4'hF, 32'h0000_0020, 0, rd);
    repeat (4) @(posedge clk24);
    bus(ra(1, REG_EVT), 4'h0, 32'h0, 0, rd);
    check("en_no_level_event", 96'(rd), 96'(0));
    bus(ra(1, REG_RISE_EN), 4'h0, 32'h0, 0, rd);
    check("rise_en_p1_read", 96'(rd), 96'(32'h0000_0020));
    check("irq_still_low", 96'(irq), 96'(0));

    // Rise on p2[3]: EVT sets after the synchroniser, irq one cycle later
    bus(ra(2, REG_RISE_EN), 4'hF, 32'h0000_0008, 0, rd);
    @(posedge clk24); #1;
    gp_in[67] = 1'b1;
    @(posedge clk24); #1;
    @(posedge clk24); #1;
    check("irq_low_in_sync", 96'(irq), 96'(0));
    @(posedge clk24); #1;
    check("irq_low_evt_cycle", 96'(irq), 96'(0));
    @(posedge clk24); #1;
    check("irq_high", 96'(irq), 96'(1));
    bus(ra(2, REG_EVT), 4'h0, 32'h0, 0, rd);
    check("evt_p2_rise", 96'(rd), 96'(32'h0000_0008));
    bus(ra(2, REG_EVT), 4'hF, 32'h0000_0008, 0, rd);
    check("irq_high_at_w1c_ack", 96'(irq_at_ack), 96'(1));
    check("irq_low_after_w1c", 96'(irq), 96'(0));
    bus(ra(2, REG_EVT), 4'h0, 32'h0, 0, rd);
    check("evt_p2_cleared", 96'(rd), 96'(0));

    // Fall edge on p0[0] lands in the same cycle as the W1C commit of bit 0
    bus(ra(0, REG_RISE_EN), 4'hF, 32'h0000_0001, 0, rd);
    bus(ra(0, REG_FALL_EN), 4'hF, 32'h0000_0001, 0, rd);
    gp_in[0] = 1'b1;
    repeat (4) @(posedge clk24);
    bus(ra(0, REG_EVT), 4'h0, 32'h0, 0, rd);
    check("evt_p0_rise", 96'(rd), 96'(32'h0000_0001));
    check("irq_p0", 96'(irq), 96'(1));
    @(posedge clk24); #1;
    gp_in[0] = 1'b0;
    bus(ra(0, REG_EVT), 4'hF, 32'h0000_0001, 1, rd);
    bus(ra(0, REG_EVT), 4'h0, 32'h0, 0, rd);
    check("evt_edge_wins_w1c", 96'(rd), 96'(32'h0000_0001));
    bus(ra(0, REG_EVT), 4'hF, 32'h0000_0001, 0, rd);
    bus(ra(0, REG_EVT), 4'h0, 32'h0, 0, rd);
    check("evt_p0_w1c_plain", 96'(rd), 96'(0));
    check("irq_all_clear", 96'(irq), 96'(0));

    // Out-of-range port 3: writes ignored, reads 0, ready still given
    bus(ra(3, REG_OUT), 4'hF, 32'hFFFF_FFFF, 0, rd);
    check("p3_write_ignored", 96'(gp_out), {32'hA5, 32'h0000_00F0, 32'h0001_FFFE});
    bus(ra(3, REG_OUT), 4'h0, 32'h0, 0, rd);
    check("p3_read_out_zero", 96'(rd), 96'(0));
    bus(ra(3, REG_IN), 4'h0, 32'h0, 0, rd);
    check("p3_read_in_zero", 96'(rd), 96'(0));

    // Reset during the ready cycle drops ready immediately
    @(posedge clk24); #1;
    sel = 1'b1; addr = ra(0, REG_OUT); wstrb = 4'h0;
    @(posedge clk24); #1;
    check("ready_before_reset", 96'(ready), 96'(1));
    reset = 1'b1;
    #1;
    check("ready_drop_on_reset", 96'(ready), 96'(0));
    check("rdata_on_reset", 96'(rdata), 96'(0));
    check("gp_out_on_reset", 96'(gp_out), {32'hA5, 32'hA5, 32'hA5});
    sel = 1'b0;
    @(posedge clk24); #1;
    reset = 1'b0;
    @(posedge clk24); #1;
    check("ready_idle_after_reset", 96'(ready), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
